// File: rtl/booth_seq_controller.sv
// booth_seq_controller
//   Sequential radix-2 Booth multiplier controller. It time-shares one
//   external carry_lookahead_adder (N = DATA_W+1) over DATA_W iterations to
//   form the signed 2*DATA_W-bit product M*Q. All multiplier state
//   (accumulator, multiplicand copy, multiplier shift register, Booth guard
//   bit, iteration counter) lives here; the adder is purely combinational.
//
//   Optional feature macro: BOOTH_ZERO_BYPASS_EN
//     defined   - a zero multiplicand or multiplier skips the iterations and
//                 goes straight to DONE with product = 0.
//     undefined - zero operands run the full DATA_W iterations.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; multiplicand, multiplier (signed)
//   out_valid / out_ready product handshake; product (signed, 2*DATA_W bits)
//   add_a, add_b, add_cin adder operands driven by this controller
//   add_result            adder result; only [DATA_W:0] is used
//
// Handshakes: a transfer happens at a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE and the
// product is held unchanged until the transfer completes.

module booth_seq_controller #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   product,
  output logic [DATA_W:0]       add_a,
  output logic [DATA_W:0]       add_b,
  output logic                  add_cin,
  input  logic [DATA_W+1:0]     add_result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nx;
  logic [DATA_W:0]       acc, acc_nx;
  logic [DATA_W:0]       mreg, mreg_nx;
  logic [DATA_W-1:0]     qreg, qreg_nx;
  logic                  g, g_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [2*DATA_W-1:0]   product_nx;
  logic [DATA_W:0]       sum;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = add_result[DATA_W:0];

  // Adder operand selection is kept in its own process so that it depends
  // only on registered state; the adder result feeds back only into the
  // next-state logic below.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a = acc;
      case ({qreg[0], g})
        2'b01: add_b = mreg;                          // ACC + M
        2'b10: begin add_b = ~mreg; add_cin = 1'b1; end // ACC - M
        default: add_b = '0;                          // pass-through
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    acc_nx     = acc;
    mreg_nx    = mreg;
    qreg_nx    = qreg;
    g_nx       = g;
    cnt_nx     = cnt;
    product_nx = product;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_nx   = '0;
          mreg_nx  = {multiplicand[DATA_W-1], multiplicand};
          qreg_nx  = multiplier;
          g_nx     = 1'b0;
          cnt_nx   = CNT_W'(DATA_W);
          state_nx = RUN;
`ifdef BOOTH_ZERO_BYPASS_EN
          if ((multiplicand == '0) || (multiplier == '0)) begin
            state_nx   = DONE;
            product_nx = '0;
          end
`endif
        end
      end
      RUN: begin
        // Arithmetic right shift of {S, Qreg, g}: S's sign bit is duplicated
        // into the new ACC MSB, S[0] enters the top of Qreg.
        acc_nx  = {sum[DATA_W], sum[DATA_W:1]};
        qreg_nx = {sum[0], qreg[DATA_W-1:1]};
        g_nx    = qreg[0];
        cnt_nx  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nx   = DONE;
          product_nx = {acc_nx[DATA_W-1:0], qreg_nx};
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mreg    <= '0;
      qreg    <= '0;
      g       <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state   <= state_nx;
      acc     <= acc_nx;
      mreg    <= mreg_nx;
      qreg    <= qreg_nx;
      g       <= g_nx;
      cnt     <= cnt_nx;
      product <= product_nx;
    end
  end

endmodule

// File: tb/tb_booth_seq_controller.sv
// tb_booth_seq_controller
//   Directed bench for booth_seq_controller with DATA_W = 8. The external
//   carry_lookahead_adder is modelled here as a plain N+1-bit sum. Expected
//   products are hand-computed and queued when an operation is issued; a
//   monitor pops and compares whenever the DUT transfers a product.

module tb_booth_seq_controller;

  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid     = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     multiplicand = '0;
  logic [DW-1:0]     multiplier   = '0;
  logic              out_valid;
  logic              out_ready    = 1'b1;
  logic [2*DW-1:0]   product;
  logic [DW:0]       add_a;
  logic [DW:0]       add_b;
  logic              add_cin;
  logic [DW+1:0]     add_result;

  booth_seq_controller #(.DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_result   (add_result)
  );

  // External adder model: plain sum, carry out in the top bit.
  assign add_result = {1'b0, add_a} + {1'b0, add_b} + {{(DW+1){1'b0}}, add_cin};

  // ---------------- scoreboard ----------------
  logic [2*DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  logic [DW:0] tr_b[8];
  logic        tr_cin[8];
  logic        adder_busy_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: product transfers happen on the edge after this sample.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_product", 32'(product), 32'hDEAD_BEEF);
      end else begin
        logic [2*DW-1:0] e;
        e = exp_q.pop_front();
        check("product", 32'(product), 32'(e));
      end
    end
  end

  always @(negedge clk) begin
    if ((add_a != '0) || (add_b != '0) || add_cin) adder_busy_seen <= 1'b1;
  end

  // Watchdog: the bench must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  // Issue one operation, measure accept-to-out_valid latency in edges,
  // optionally hold out_ready low for 'stall' cycles, then complete the
  // transfer and check the return to IDLE.
  task automatic run_op(input logic [DW-1:0] m, input logic [DW-1:0] q,
                        input logic [2*DW-1:0] exp, input int lat_exp, input int stall);
    int lat;
    int guard;
    @(posedge clk); #2;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid     = 1'b1;
    multiplicand = m;
    multiplier   = q;
    out_ready    = (stall == 0);
    exp_q.push_back(exp);
    @(posedge clk); #2;            // accept edge
    in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat <= 40) begin
      if (lat < 8) begin
        tr_b[lat]   = add_b;
        tr_cin[lat] = add_cin;
      end
      lat++;
      @(negedge clk);
    end
    check("latency", 32'(lat), 32'(lat_exp));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #2;
      in_valid     = 1'b1;         // must be ignored while DONE
      multiplicand = DW'($urandom_range(0, 255));
      multiplier   = DW'($urandom_range(0, 255));
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_product", 32'(product), 32'(exp));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_adder_idle", 32'({add_a, add_b, add_cin}), 32'd0);
    end
    if (stall > 0) begin
      @(posedge clk); #2;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);                // handshake edge
    @(negedge clk);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  logic [DW:0] exp_b[8]   = '{9'h000, 9'h1FA, 9'h000, 9'h005, 9'h000, 9'h000, 9'h000, 9'h000};
  logic        exp_cin[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

`ifdef BOOTH_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 8;
`endif

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_adder", 32'({add_a, add_b, add_cin}), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    run_op(8'd3,   8'hFB, 16'hFFF1, 8, 0);   //    3 *   -5
    run_op(8'h80,  8'h80, 16'h4000, 8, 0);   // -128 * -128
    run_op(8'd127, 8'h80, 16'hC080, 8, 0);   //  127 * -128
    run_op(8'hFF,  8'hFF, 16'h0001, 8, 0);   //   -1 *   -1
    run_op(8'd7,   8'd6,  16'h002A, 8, 5);   // backpressure

    // Reset during iteration 4 of 9*9: discarded, nothing emitted.
    @(posedge clk); #2;
    in_valid = 1'b1; multiplicand = 8'd9; multiplier = 8'd9; out_ready = 1'b1;
    @(posedge clk); #2 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2 rst_n = 1'b1;
    run_op(8'd2, 8'hFD, 16'hFFFA, 8, 0);     //    2 *   -3

    // Adder sequencing for 5 * 6
    run_op(8'd5, 8'd6, 16'h001E, 8, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("seq_add_b[%0d]", i), 32'(tr_b[i]), 32'(exp_b[i]));
      check($sformatf("seq_add_cin[%0d]", i), 32'(tr_cin[i]), 32'(exp_cin[i]));
    end

    // Zero multiplicand
    @(negedge clk);
    adder_busy_seen = 1'b0;
    run_op(8'd0, 8'hB3, 16'h0000, ZERO_LAT, 0); // 0 * -77
`ifdef BOOTH_ZERO_BYPASS_EN
    check("bypass_adder_idle", 32'(adder_busy_seen), 32'd0);
`endif

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
